// File: rtl/spi_master_ctrl.sv
// SPI master: runtime CPOL/CPHA, programmable SCLK divider, MSB/LSB-first, decoded active-low slave select.
// Optional SPI_LOOPBACK_EN adds a LOOP input that routes the internal MOSI back into the receive path.
module spi_master_ctrl #(
    parameter int unsigned word_width = 8,
    parameter int unsigned SS_width   = 4,
    parameter int unsigned div_width  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        CPOL,
    input  logic                        CPHA,
    input  logic                        LSBF,
    input  logic [div_width-1:0]        DIV,
    input  logic [$clog2(SS_width)-1:0] SSV,
    input  logic [word_width-1:0]       D_IN,
    output logic [word_width-1:0]       D_OUT,
    output logic                        busy,
    output logic                        done,
    output logic                        SCLK,
    output logic                        SD_OUT,
`ifdef SPI_LOOPBACK_EN
    input  logic                        LOOP,
`endif
    input  logic                        SD_IN,
    output logic [SS_width-1:0]         SS_OUT
);

    localparam int unsigned ECNT_W = $clog2(2 * word_width);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                 state, state_nxt;
    logic                   cpha_q, lsbf_q;
    logic [div_width-1:0]   div_q, cnt;
    logic [ECNT_W-1:0]      ecnt;
    logic [word_width-1:0]  tx_sr, rx_sr;

    logic                   accept_c, finish_c, edge_c, tick_c, last_edge_c;
    logic                   sample_c, shift_c, rx_in_c, tx_first_c, tx_next_c;
    logic [word_width-1:0]  tx_load_c, tx_shift_c, rx_shift_c;
    logic [SS_width-1:0]    ss_sel_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        finish_c  = 1'b0;
        edge_c    = 1'b0;
        case (state)
            IDLE:  if (start && !busy && !done) begin
                       accept_c  = 1'b1;
                       state_nxt = SETUP;
                   end
            SETUP: if (tick_c) state_nxt = XFER;
            XFER:  if (tick_c) begin
                       edge_c = 1'b1;
                       if (last_edge_c) state_nxt = HOLD;
                   end
            HOLD:  if (tick_c) begin
                       finish_c  = 1'b1;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    assign tick_c      = (state != IDLE) && (cnt == div_q);
    assign last_edge_c = (ecnt == ECNT_W'(2 * word_width - 1));
    // Even edge index is a leading edge; CPHA picks which edge type samples
    assign sample_c    = edge_c && (ecnt[0] == cpha_q);
    assign shift_c     = edge_c && (ecnt[0] != cpha_q);

`ifdef SPI_LOOPBACK_EN
    assign rx_in_c = LOOP ? SD_OUT : SD_IN;
`else
    assign rx_in_c = SD_IN;
`endif

    // Bit-order dependent shift helpers
    always_comb begin
        tx_first_c = LSBF ? D_IN[0] : D_IN[word_width-1];
        tx_load_c  = LSBF ? (D_IN >> 1) : (D_IN << 1);
        tx_next_c  = lsbf_q ? tx_sr[0] : tx_sr[word_width-1];
        tx_shift_c = lsbf_q ? (tx_sr >> 1) : (tx_sr << 1);
        rx_shift_c = lsbf_q ? {rx_in_c, rx_sr[word_width-1:1]}
                            : {rx_sr[word_width-2:0], rx_in_c};
        for (int unsigned i = 0; i < SS_width; i++) begin
            ss_sel_c[i] = (32'(SSV) != i);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cpha_q <= 1'b0;
            lsbf_q <= 1'b0;
            div_q  <= '0;
            cnt    <= '0;
            ecnt   <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            D_OUT  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            SCLK   <= 1'b0;
            SD_OUT <= 1'b0;
            SS_OUT <= '1;
        end else begin
            done <= 1'b0;
            if (state == IDLE) SCLK <= CPOL;
            if (state != IDLE) cnt <= tick_c ? '0 : cnt + div_width'(1);
            if (accept_c) begin
                cpha_q <= CPHA;
                lsbf_q <= LSBF;
                div_q  <= DIV;
                cnt    <= '0;
                ecnt   <= '0;
                rx_sr  <= '0;
                busy   <= 1'b1;
                SS_OUT <= ss_sel_c;
                // CPHA=0 puts the first bit out before the first leading edge
                if (!CPHA) begin
                    SD_OUT <= tx_first_c;
                    tx_sr  <= tx_load_c;
                end else begin
                    tx_sr  <= D_IN;
                end
            end
            if (edge_c) begin
                SCLK <= ~SCLK;
                ecnt <= ecnt + ECNT_W'(1);
            end
            if (sample_c) rx_sr <= rx_shift_c;
            if (shift_c) begin
                SD_OUT <= tx_next_c;
                tx_sr  <= tx_shift_c;
            end
            if (finish_c) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                SS_OUT <= '1;
                D_OUT  <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave on the pins.
// Define SPI_LOOPBACK_EN to also exercise the LOOP path.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, CPOL, CPHA, LSBF;
    logic [7:0] DIV, D_IN, D_OUT;
    logic [1:0] SSV;
    logic [3:0] SS_OUT;
    logic       busy, done, SCLK, SD_OUT;
    logic       SD_IN = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic       LOOP;
`endif

    int total = 0, bad = 0, done_cnt = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.word_width(8), .SS_width(4), .div_width(8)) dut (
        .clk(clk), .rst(rst), .start(start), .CPOL(CPOL), .CPHA(CPHA), .LSBF(LSBF),
        .DIV(DIV), .SSV(SSV), .D_IN(D_IN), .D_OUT(D_OUT), .busy(busy), .done(done),
        .SCLK(SCLK), .SD_OUT(SD_OUT),
`ifdef SPI_LOOPBACK_EN
        .LOOP(LOOP),
`endif
        .SD_IN(SD_IN), .SS_OUT(SS_OUT)
    );

    // Slave model: reacts to SS and SCLK changes observed on the falling clk edge
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsbf = 1'b0, s_mute = 1'b0;
    logic [7:0] s_tx = 8'h00, s_sr = 8'h00, s_rx = 8'h00, s_seq = 8'h00;
    logic       ss_prev = 1'b0, sclk_prev = 1'b0, s_act;
    int         cyc = 0, last_tog = -1, gap = 0, gap_min = 0, gap_max = 0, toggles = 0;

    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) done_cnt++;
        s_act = (rst === 1'b0) && (SS_OUT !== 4'b1111);
        if (s_act && !ss_prev) begin
            s_sr = s_tx; s_rx = 8'h00; s_seq = 8'h00;
            toggles = 0; gap_min = 1000; gap_max = 0; last_tog = -1;
            if (!s_cpha) begin
                SD_IN = s_mute ? 1'b0 : (s_lsbf ? s_sr[0] : s_sr[7]);
                s_sr  = s_lsbf ? (s_sr >> 1) : (s_sr << 1);
            end
        end else if (s_act && (SCLK !== sclk_prev)) begin
            toggles++;
            if (last_tog >= 0) begin
                gap = cyc - last_tog;
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            last_tog = cyc;
            if ((sclk_prev == s_cpol) ^ s_cpha) begin
                s_rx  = s_lsbf ? {SD_OUT, s_rx[7:1]} : {s_rx[6:0], SD_OUT};
                s_seq = {s_seq[6:0], SD_OUT};
            end else begin
                SD_IN = s_mute ? 1'b0 : (s_lsbf ? s_sr[0] : s_sr[7]);
                s_sr  = s_lsbf ? (s_sr >> 1) : (s_sr << 1);
            end
        end
        ss_prev   = s_act;
        sclk_prev = SCLK;
    end

    task automatic start_xfer(input logic cpol, input logic cpha, input logic lsbf,
                              input logic [7:0] div, input logic [1:0] ssv,
                              input logic [7:0] din, input logic [7:0] slv);
        @(negedge clk);
        CPOL = cpol; CPHA = cpha; LSBF = lsbf; DIV = div; SSV = ssv; D_IN = din;
        s_cpol = cpol; s_cpha = cpha; s_lsbf = lsbf; s_tx = slv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; CPOL = 1'b0; CPHA = 1'b0; LSBF = 1'b0;
        DIV = 8'd0; SSV = 2'd0; D_IN = 8'h00;
`ifdef SPI_LOOPBACK_EN
        LOOP = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if (D_OUT !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", D_OUT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", SCLK); end
        total++; if (SD_OUT !== 1'b0) begin bad++; $display("FAIL rst_sdout got=%b exp=0", SD_OUT); end
        total++; if (SS_OUT !== 4'b1111) begin bad++; $display("FAIL rst_ss got=%b exp=1111", SS_OUT); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0;
        int lat, d0;
        d0 = done_cnt;
        start_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'h3C);
        total++; if (SS_OUT !== 4'b1110) begin bad++; $display("FAIL m0_ss got=%b exp=1110", SS_OUT); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL m0_busy got=%b exp=1", busy); end
        wait_done(100, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL m0_latency got=%0d exp=18", lat); end
        total++; if (D_OUT !== 8'h3C) begin bad++; $display("FAIL m0_dout got=%h exp=3c", D_OUT); end
        total++; if (s_rx !== 8'hA5) begin bad++; $display("FAIL m0_slave_rx got=%h exp=a5", s_rx); end
        repeat (2) @(negedge clk); #1;
        total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL m0_sclk_idle got=%b exp=0", SCLK); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL m0_done_pulses got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_mode3_div;
        int lat;
        start_xfer(1'b1, 1'b1, 1'b0, 8'd2, 2'd2, 8'h81, 8'h7E);
        total++; if (SS_OUT !== 4'b1011) begin bad++; $display("FAIL m3_ss got=%b exp=1011", SS_OUT); end
        wait_done(200, lat);
        total++; if (lat != 54) begin bad++; $display("FAIL m3_latency got=%0d exp=54", lat); end
        total++; if (D_OUT !== 8'h7E) begin bad++; $display("FAIL m3_dout got=%h exp=7e", D_OUT); end
        total++; if (s_rx !== 8'h81) begin bad++; $display("FAIL m3_slave_rx got=%h exp=81", s_rx); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle got=%b exp=1", SCLK); end
        total++; if (toggles != 16) begin bad++; $display("FAIL m3_toggles got=%0d exp=16", toggles); end
        total++; if (gap_min != 3 || gap_max != 3) begin bad++; $display("FAIL m3_half_period got=%0d..%0d exp=3", gap_min, gap_max); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lsb_first;
        int lat;
        start_xfer(1'b0, 1'b1, 1'b1, 8'd0, 2'd1, 8'h01, 8'h01);
        wait_done(100, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL lsb_latency got=%0d exp=18", lat); end
        total++; if (s_seq !== 8'h80) begin bad++; $display("FAIL lsb_mosi_seq got=%b exp=10000000", s_seq); end
        total++; if (s_rx !== 8'h01) begin bad++; $display("FAIL lsb_slave_rx got=%h exp=01", s_rx); end
        total++; if (D_OUT !== 8'h01) begin bad++; $display("FAIL lsb_dout got=%h exp=01", D_OUT); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int lat, d0;
        d0 = done_cnt;
        start_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd1, 8'h3C, 8'hC3);
        repeat (4) @(negedge clk);
        D_IN = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (SS_OUT !== 4'b1101) begin bad++; $display("FAIL busy_ss got=%b exp=1101", SS_OUT); end
        wait_done(100, lat);
        total++; if (lat != 13) begin bad++; $display("FAIL busy_latency got=%0d exp=13", lat); end
        total++; if (s_rx !== 8'h3C) begin bad++; $display("FAIL busy_slave_rx got=%h exp=3c", s_rx); end
        total++; if (D_OUT !== 8'hC3) begin bad++; $display("FAIL busy_dout got=%h exp=c3", D_OUT); end
        repeat (30) @(negedge clk); #1;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt - d0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort;
        int lat, d0;
        start_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'hA5, 8'h3C);
        total++; if (SS_OUT !== 4'b0111) begin bad++; $display("FAIL abort_ss_on got=%b exp=0111", SS_OUT); end
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (SS_OUT !== 4'b1111) begin bad++; $display("FAIL abort_ss got=%b exp=1111", SS_OUT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (D_OUT !== 8'h00) begin bad++; $display("FAIL abort_dout got=%h exp=00", D_OUT); end
        total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL abort_sclk got=%b exp=0", SCLK); end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk); #1;
        total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        start_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'hC3, 8'h96);
        wait_done(100, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=18", lat); end
        total++; if (D_OUT !== 8'h96) begin bad++; $display("FAIL abort_restart_dout got=%h exp=96", D_OUT); end
        total++; if (s_rx !== 8'hC3) begin bad++; $display("FAIL abort_restart_slave_rx got=%h exp=c3", s_rx); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        start_xfer(1'b0, 1'b0, 1'b1, 8'd0, 2'd1, 8'h96, 8'h69);
        wait_done(100, lat);
        total++; if (D_OUT !== 8'h69) begin bad++; $display("FAIL b2b_first_dout got=%h exp=69", D_OUT); end
        // start raised during the done cycle must be ignored, then taken one cycle later
        D_IN = 8'h5A; SSV = 2'd2; s_tx = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || SS_OUT !== 4'b1111) begin bad++; $display("FAIL b2b_ignored got=%b/%b exp=0/1111", busy, SS_OUT); end
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1 || SS_OUT !== 4'b1011) begin bad++; $display("FAIL b2b_accepted got=%b/%b exp=1/1011", busy, SS_OUT); end
        wait_done(100, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL b2b_latency got=%0d exp=18", lat); end
        total++; if (D_OUT !== 8'hA5) begin bad++; $display("FAIL b2b_dout got=%h exp=a5", D_OUT); end
        total++; if (s_rx !== 8'h5A) begin bad++; $display("FAIL b2b_slave_rx got=%h exp=5a", s_rx); end
        repeat (2) @(negedge clk);
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback;
        int lat;
        s_mute = 1'b1; LOOP = 1'b1;
        start_xfer(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h5A, 8'hFF);
        wait_done(100, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL loop_latency got=%0d exp=18", lat); end
        total++; if (D_OUT !== 8'h5A) begin bad++; $display("FAIL loop_dout got=%h exp=5a", D_OUT); end
        s_mute = 1'b0; LOOP = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3_div();
        test_lsb_first();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
